cotm32_clint_mh: RTL

COTM32_CLINT_MH -- requirements
Module: cotm32_clint_mh

---
 rtl/cotm32_clint_mh.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cotm32_clint_mh.sv
// rtl/cotm32_clint_mh.sv - Core-local interruptor: per-hart MSIP/MTIMECMP, shared 64-bit MTIME
//
// Purpose:
//   Memory-mapped CLINT with one software-interrupt bit and one 64-bit timer
//   compare per hart, plus a free-running 64-bit mtime advanced every TICK_DIV
//   clocks. Single-cycle request/response bus: every accepted request gets a
//   registered response on the following cycle, and there is no backpressure.
//
// Parameters:
//   NUM_HARTS  harts served (1..4095)
//   BASE_ADDR  byte base of the 64 KiB window
//   TICK_DIV   clk cycles per mtime increment (1..65535)
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_halt                (only with COTM32_CLINT_MTIME_HALT_EN) freeze prescaler and mtime
//   i_req/i_we/i_addr     request strobe, write flag, byte address
//   i_wdata/i_wstrb       write data and byte enables
//   o_rdata/o_rvalid/o_err registered response
//   o_msip/o_mtip         per-hart software / timer interrupt pending
//
// Optional feature macro: COTM32_CLINT_MTIME_HALT_EN

module cotm32_clint_mh #(
  parameter int unsigned NUM_HARTS = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef COTM32_CLINT_MTIME_HALT_EN
  input  logic                 i_halt,
`endif
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_wdata,
  input  logic [3:0]           i_wstrb,
  output logic [31:0]          o_rdata,
  output logic                 o_rvalid,
  output logic                 o_err,
  output logic [NUM_HARTS-1:0] o_msip,
  output logic [NUM_HARTS-1:0] o_mtip
);

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  logic [63:0]          mtime_q, mtime_d;
  logic [15:0]          presc_q, presc_d;
  logic [63:0]          cmp_q [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q;
  logic [31:0]          rdata_q;
  logic                 rvalid_q, err_q;

  logic        run, tick;
  logic [31:0] off;
  logic        sel_msip, sel_cmp, sel_mtime, hi_word, hart_ok, addr_ok, wr;
  logic [11:0] hart;
  logic        msip_rd;
  logic [63:0] cmp_rd;
  logic [31:0] rd_val;

`ifdef COTM32_CLINT_MTIME_HALT_EN
  assign run = ~i_halt;
`else
  assign run = 1'b1;
`endif

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

  // Address decode on the window offset; an address below BASE wraps to a
  // huge offset and so falls outside every region.
  always_comb begin
    off       = i_addr - BASE_ADDR;
    sel_msip  = (off < 32'h0000_4000);
    sel_cmp   = (off >= 32'h0000_4000) && (off < 32'h0000_BFF8);
    sel_mtime = (off[31:3] == 29'h0000_17FF);
    hi_word   = off[2];
    // MTIMECMP index is (off-0x4000)/8; dropping bit 15 is harmless modulo 4096.
    hart      = sel_msip ? off[13:2] : (off[14:3] - 12'h800);
    hart_ok   = ({20'b0, hart} < NUM_HARTS);
    addr_ok   = (off[1:0] == 2'b00) && (sel_mtime || ((sel_msip || sel_cmp) && hart_ok));
    wr        = i_req && i_we && addr_ok;
  end

  always_comb begin
    msip_rd = 1'b0;
    cmp_rd  = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hart == 12'(h)) begin
        msip_rd = msip_q[h];
        cmp_rd  = cmp_q[h];
      end
    end
    rd_val = '0;
    if (sel_msip)       rd_val = {31'b0, msip_rd};
    else if (sel_cmp)   rd_val = hi_word ? cmp_rd[63:32] : cmp_rd[31:0];
    else if (sel_mtime) rd_val = hi_word ? mtime_q[63:32] : mtime_q[31:0];
  end

  // Timebase. An MTIME write replaces the increment for that edge but leaves
  // the prescaler phase alone.
  always_comb begin
    tick    = run && (presc_q == PRESC_MAX);
    presc_d = presc_q;
    if (run) presc_d = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr && sel_mtime) begin
      mtime_d = mtime_q;
      if (hi_word) mtime_d[63:32] = merge(mtime_q[63:32], i_wdata, i_wstrb);
      else         mtime_d[31:0]  = merge(mtime_q[31:0], i_wdata, i_wstrb);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q  <= '0;
      presc_q  <= '0;
      msip_q   <= '0;
      for (int h = 0; h < NUM_HARTS; h++) cmp_q[h] <= '1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      mtime_q <= mtime_d;
      presc_q <= presc_d;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr && hart == 12'(h)) begin
          if (sel_msip && i_wstrb[0]) msip_q[h] <= i_wdata[0];
          if (sel_cmp) begin
            if (hi_word) cmp_q[h][63:32] <= merge(cmp_q[h][63:32], i_wdata, i_wstrb);
            else         cmp_q[h][31:0]  <= merge(cmp_q[h][31:0], i_wdata, i_wstrb);
          end
        end
      end
      rvalid_q <= i_req;
      err_q    <= i_req && !addr_ok;
      rdata_q  <= (i_req && !i_we && addr_ok) ? rd_val : 32'h0;
    end
  end

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_irq
    assign o_mtip[g] = (mtime_q >= cmp_q[g]);
  end

  assign o_msip   = msip_q;
  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_err    = err_q;

endmodule
